// File: rtl/dcache_ctrl_if.sv
// Core data-cache port plus backing-memory port of the data cache.
// slave = cache controller side, master = core/memory environment side.
interface dcache_ctrl_if;
  logic        dcache_r_en;
  logic        dcache_w_en;
  logic [15:0] dcache_addr;
  logic [15:0] dcache_w_data;
  logic [15:0] dcache_r_data;
  logic        dcache_ready;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_w_data;
  logic        mem_ack;
  logic [15:0] mem_r_data;

  modport slave (
    input  dcache_r_en, dcache_w_en,
    input  dcache_addr, dcache_w_data,
    output dcache_r_data, dcache_ready,
    output mem_req, mem_we,
    output mem_addr, mem_w_data,
    input  mem_ack, mem_r_data
  );

  modport master (
    output dcache_r_en, dcache_w_en,
    output dcache_addr, dcache_w_data,
    input  dcache_r_data, dcache_ready,
    input  mem_req, mem_we,
    input  mem_addr, mem_w_data,
    output mem_ack, mem_r_data
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-line, write-through,
// no-write-allocate data cache controller.
module dcache_ctrl #(
  parameter int INDEX_BITS = 4
) (
  input  logic          clk,
  input  logic          reset,
  dcache_ctrl_if.slave  bus
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 16 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE, FILL, WRITE, DONE
  } state_e;

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic [15:0] r_data_q, r_data_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_w_data_q, mem_w_data_d;
  logic [LINES-1:0] valid_q, valid_d;

  logic [TAG_W-1:0] tag_q  [LINES];
  logic [15:0]      data_q [LINES];

  logic [INDEX_BITS-1:0] c_idx, m_idx;
  logic [TAG_W-1:0]      c_tag, m_tag;
  logic                  c_hit, m_hit;

  logic                  arr_we;
  logic [15:0]           arr_data;

  assign c_idx = bus.dcache_addr[INDEX_BITS-1:0];
  assign c_tag = bus.dcache_addr[15:INDEX_BITS];
  assign m_idx = mem_addr_q[INDEX_BITS-1:0];
  assign m_tag = mem_addr_q[15:INDEX_BITS];

  assign c_hit = valid_q[c_idx] && (tag_q[c_idx] == c_tag);
  assign m_hit = valid_q[m_idx] && (tag_q[m_idx] == m_tag);

  always_comb begin
    state_d      = state_q;
    ready_d      = 1'b0;
    r_data_d     = r_data_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_w_data_d = mem_w_data_q;
    valid_d      = valid_q;
    arr_we       = 1'b0;
    arr_data     = bus.mem_r_data;
    unique case (state_q)
      IDLE: begin
        if (bus.dcache_w_en) begin
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b1;
          mem_addr_d   = bus.dcache_addr;
          mem_w_data_d = bus.dcache_w_data;
          state_d      = WRITE;
        end else if (bus.dcache_r_en) begin
          if (c_hit) begin
            r_data_d = data_q[c_idx];
            ready_d  = 1'b1;
            state_d  = DONE;
          end else begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = bus.dcache_addr;
            state_d    = FILL;
          end
        end
      end
      FILL: begin
        if (bus.mem_ack) begin
          valid_d[m_idx] = 1'b1;
          arr_we         = 1'b1;
          r_data_d       = bus.mem_r_data;
          mem_req_d      = 1'b0;
          ready_d        = 1'b1;
          state_d        = DONE;
        end
      end
      WRITE: begin
        if (bus.mem_ack) begin
          // Update only a resident line; misses never allocate.
          arr_we    = m_hit;
          arr_data  = mem_w_data_q;
          mem_req_d = 1'b0;
          ready_d   = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      r_data_q     <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_w_data_q <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      r_data_q     <= r_data_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_w_data_q <= mem_w_data_d;
      valid_q      <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_q[m_idx]  <= m_tag;
      data_q[m_idx] <= arr_data;
    end
  end

  assign bus.dcache_ready  = ready_q;
  assign bus.dcache_r_data = r_data_q;
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_w_data    = mem_w_data_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: random core accesses
// against a line-address cache model and a backing memory.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dcache_ctrl_if mif ();

  dcache_ctrl #(.INDEX_BITS(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (mif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [15:0] data;
    int          acks;
    bit          hit;
  } exp_t;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] data;
  } mop_t;

  exp_t eq [$];
  mop_t mq [$];

  logic [15:0] ref_mem [int];
  int          line_addr [16];
  logic [15:0] last_rd;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int issue_cyc = 0;
  int acks = 0;
  int fixed_delay = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_rd(logic [15:0] a);
    if (!ref_mem.exists(int'(a)))
      ref_mem[int'(a)] = 16'($urandom);
    return ref_mem[int'(a)];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) line_addr[i] = -1;
    last_rd = 16'h0000;
  endtask

  // Backing memory: acks after a random or fixed wait.
  initial begin
    bit busy = 0;
    int cnt = 0;
    mif.mem_ack    = 1'b0;
    mif.mem_r_data = 16'h0000;
    forever begin
      @(negedge clk);
      mif.mem_ack    = 1'b0;
      mif.mem_r_data = 16'($urandom);
      if (!rst_n) begin
        busy = 0;
      end else if (mif.mem_req) begin
        if (!busy) begin
          busy = 1;
          cnt = (fixed_delay >= 0) ? fixed_delay
                                   : int'($urandom_range(0, 3));
        end
        if (cnt == 0) begin
          mop_t m;
          busy = 0;
          acks++;
          mif.mem_ack = 1'b1;
          if (!mif.mem_we)
            mif.mem_r_data = mem_rd(mif.mem_addr);
          if (mq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mem_unexpected: got addr %h we %0d expected none",
                     mif.mem_addr, mif.mem_we);
          end else begin
            m = mq.pop_front();
            chk("mem_we", 16'(mif.mem_we), 16'(m.we));
            chk("mem_addr", mif.mem_addr, m.addr);
            if (m.we) chk("mem_w_data", mif.mem_w_data, m.data);
          end
        end else begin
          cnt--;
        end
      end
    end
  end

  // Response monitor.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mif.dcache_ready) begin
        if (eq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL ready_unexpected: got ready 1 expected 0");
        end else begin
          exp_t e;
          e = eq.pop_front();
          chk(e.is_rd ? "r_data" : "r_data_hold",
              mif.dcache_r_data, e.data);
          chk("mem_acks", 16'(acks), 16'(e.acks));
          if (e.hit)
            chk("hit_latency", 16'(cyc - issue_cyc), 16'd1);
        end
        acks = 0;
      end
    end
  end

  task automatic access(bit we, logic [15:0] a, logic [15:0] d);
    int   i;
    int   n;
    exp_t e;
    i = int'(a[3:0]);
    e.is_rd = !we;
    e.hit   = 0;
    e.acks  = 1;
    if (we) begin
      ref_mem[int'(a)] = d;
      mq.push_back('{1'b1, a, d});
      e.data = last_rd;
    end else begin
      e.data = mem_rd(a);
      if (line_addr[i] == int'(a)) begin
        e.hit  = 1;
        e.acks = 0;
      end else begin
        line_addr[i] = int'(a);
        mq.push_back('{1'b0, a, 16'h0000});
      end
      last_rd = e.data;
    end
    eq.push_back(e);
    @(negedge clk);
    mif.dcache_w_en   = we;
    mif.dcache_r_en   = !we;
    mif.dcache_addr   = a;
    mif.dcache_w_data = d;
    issue_cyc = cyc;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!mif.dcache_ready && n < 60);
    if (!mif.dcache_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got no ready expected ready addr %h", a);
    end
    mif.dcache_w_en = 1'b0;
    mif.dcache_r_en = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    logic [11:0] tags [4];
    tags[0] = 12'h000;
    tags[1] = 12'h001;
    tags[2] = 12'h002;
    tags[3] = 12'hFFF;
    mif.dcache_r_en   = 1'b0;
    mif.dcache_w_en   = 1'b0;
    mif.dcache_addr   = 16'h0000;
    mif.dcache_w_data = 16'h0000;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", 16'(mif.dcache_ready), 16'd0);
    chk("rst_r_data", mif.dcache_r_data, 16'h0000);
    chk("rst_mem_req", 16'(mif.mem_req), 16'd0);
    chk("rst_mem_we", 16'(mif.mem_we), 16'd0);
    chk("rst_mem_addr", mif.mem_addr, 16'h0000);
    chk("rst_mem_w_data", mif.mem_w_data, 16'h0000);
    #2 rst_n = 1'b1;
    @(negedge clk);

    ref_mem[16'h0012] = 16'hBEEF;
    fixed_delay = 3;
    access(0, 16'h0012, 16'h0000);
    fixed_delay = -1;
    access(0, 16'h0012, 16'h0000);
    access(1, 16'h0012, 16'h1234);
    access(0, 16'h0012, 16'h0000);
    access(1, 16'h0034, 16'h5555);
    access(0, 16'h0034, 16'h0000);
    access(0, 16'h0012, 16'h0000);
    access(0, 16'h0022, 16'h0000);
    access(0, 16'h0012, 16'h0000);

    // Reset while a fill is outstanding.
    fixed_delay = 20;
    @(negedge clk);
    mif.dcache_r_en = 1'b1;
    mif.dcache_addr = 16'h0042;
    repeat (3) @(posedge clk);
    #1 chk("fill_mem_req", 16'(mif.mem_req), 16'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_fill_mem_req", 16'(mif.mem_req), 16'd0);
    chk("rst_fill_ready", 16'(mif.dcache_ready), 16'd0);
    mif.dcache_r_en = 1'b0;
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    fixed_delay = -1;
    access(0, 16'h0012, 16'h0000);

    for (int k = 0; k < 300; k++) begin
      logic [15:0] a;
      a = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15))};
      access($urandom_range(0, 2) == 0, a, 16'($urandom));
    end

    repeat (5) @(posedge clk);
    chk("resp_queue_empty", 16'(eq.size()), 16'd0);
    chk("mem_queue_empty", 16'(mq.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
